vdispatch_issuer: RTL and testbench
===================================

// Module: vdispatch_issuer
// PURPOSE
//  Feeds the vector dispatcher ring from the decode side. It accepts decoded vector
//  instructions over a valid/ready handshake and computes element-group counts.
//  It keeps a shadow of per-slot occupancy and remaining groups, and drives shift,
//  increment and the add/sub controls. Each slot therefore steps through its elements
//  and exits the ring exactly when done. Sits between vector decode and the dispatcher.
// PARAMETERS
//  NUMSTAGES  2    dispatcher slots; slot 0 = insertion end, slot NUMSTAGES-1 = exit end
//  WIDTH      157  instruction word width
//  ELMWIDTH   7    element index / vector length width
//  CNTWIDTH   3    group counter width; must hold ceil((2^ELMWIDTH-1)/LANES)
//  LANES      32   elements per group (power of two)
//  LOG2LANES  5    log2(LANES)
// PORTS
//  clk               in   1                 clock, rising edge
//  reset             in   1                 synchronous, active-high
//  in_valid          in   1                 decoded instruction available
//  in_ready          out  1                 instruction accepted this cycle (in_valid&in_ready)
//  in_instr          in   WIDTH             instruction word
//  in_vl             in   ELMWIDTH          vector length in elements
//  stall             in   1                 downstream lanes busy; freeze everything
//  shift             out  1                 dispatcher shift enable
//  rotate            out  1                 dispatcher rotate; held 0 by this block
//  inshift_instr     out  WIDTH             word inserted at slot 0 on shift
//  inshift_first     out  1                 1 for a real instruction, 0 for bubble
//  inshift_rdelm     out  ELMWIDTH          start read element, always 0
//  inshift_wrelm     out  ELMWIDTH          start write element, always 0
//  inshift_count     out  CNTWIDTH          group count of inserted instruction
//  increment         out  NUMSTAGES         per-slot step enable
//  rdelm_add_sub     out  1                 0 (add)
//  wrelm_add_sub     out  1                 0 (add)
//  count_add_sub     out  1                 1 (subtract)
//  rdelm_valuetoadd  out  ELMWIDTH          LANES
//  wrelm_valuetoadd  out  ELMWIDTH          LANES
//  count_valuetoadd  out  CNTWIDTH          1
//  retire            out  1                 pulse: valid instruction leaves exit slot
//  busy              out  1                 any shadow slot valid
// BEHAVIOUR
//  - State: per slot valid[i], rem[i] (CNTWIDTH). Reset clears all; during reset
//    in_ready=0, shift=0, increment=0, retire=0, busy=0; inshift_* = 0.
//  - Control outputs are combinational from state and inputs (dispatcher registers them).
//  - The groups computation is performed at ELMWIDTH+1 bits, then truncated to CNTWIDTH.
//    groups = (in_vl + LANES-1) >> LOG2LANES; inshift_count = groups.
//  - exit_done = ~valid[N-1] | (rem[N-1]==0).
//  - Each cycle with stall=0:
//    * SHIFT when exit_done & (busy | in_valid): shift=1, increment=0, in_ready=1.
//      Slot i+1 <= slot i. Slot 0 <= {in_valid, groups}, or bubble {0,0} if no in_valid.
//      Bubble drives inshift_instr=0 and inshift_first=0.
//      retire=valid[N-1]. Accept happens iff in_valid.
//    * STEP otherwise: shift=0, in_ready=0.
//      increment[i] = valid[i] & (rem[i]!=0), and rem[i] decrements where set.
//    * Idle (all empty, no in_valid): shift=0, increment=0, in_ready=1.
//  - No increment is ever asserted in a shift cycle. Counters never underflow.
//  - stall=1: shift=0, increment=0, in_ready=0, retire=0; state frozen.
//  - vl=0: inserted with rem=0, never incremented, retires on its first exit shift.
//  - Reset mid-operation: drops all in-flight slots, no retire pulse, idle next cycle.
// TESTING
//  1. reset=1 for 2 cycles with in_valid=1 -> in_ready=0, shift=0, increment=0, busy=0.
//  2. One instr vl=70, stall=0 -> t0 accept shift=1 inshift_count=3 first=1;
//     t1 bubble shift; t2..t4 increment=2'b10; t5 shift, retire=1; t6 busy=0.
//  3. A,B vl=32 back-to-back -> t0 accept A; t1 accept B; t2 increment=2'b11;
//     t3 shift retires A, B in slot 1; t4 bubble shift retires B.
//  4. vl=0 -> accepted with inshift_count=0; zero increments asserted; retires on exit shift.
//  5. stall=1 for 3 cycles during vl=96 run -> outputs 0, rem frozen; after release exactly
//     the remaining increments occur, total 3.
//  6. reset asserted at t3 of scenario 2 -> retire never pulses; busy=0, in_ready=1 after.

Source files
------------

// File: rtl/vdispatch_issuer_if.sv
// Decode-side handshake into the vector dispatch issuer: one decoded
// instruction plus its vector length, transferred when in_valid & in_ready.
interface vdispatch_issuer_if #(
    parameter int WIDTH    = 157,
    parameter int ELMWIDTH = 7
);
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    in_instr;
    logic [ELMWIDTH-1:0] in_vl;

    modport master (output in_valid, output in_instr, output in_vl, input in_ready);
    modport slave  (input in_valid, input in_instr, input in_vl, output in_ready);
endinterface

// File: rtl/vdispatch_issuer.sv
// Vector dispatch issuer: inserts decoded instructions into the dispatcher ring,
// shadows per-slot occupancy / remaining groups and drives shift/step controls.
module vdispatch_issuer #(
    parameter int NUMSTAGES = 2,
    parameter int WIDTH     = 157,
    parameter int ELMWIDTH  = 7,
    parameter int CNTWIDTH  = 3,
    parameter int LANES     = 32,
    parameter int LOG2LANES = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    vdispatch_issuer_if.slave    dec,
    input  logic                 stall,
    output logic                 shift,
    output logic                 rotate,
    output logic [WIDTH-1:0]     inshift_instr,
    output logic                 inshift_first,
    output logic [ELMWIDTH-1:0]  inshift_rdelm,
    output logic [ELMWIDTH-1:0]  inshift_wrelm,
    output logic [CNTWIDTH-1:0]  inshift_count,
    output logic [NUMSTAGES-1:0] increment,
    output logic                 rdelm_add_sub,
    output logic                 wrelm_add_sub,
    output logic                 count_add_sub,
    output logic [ELMWIDTH-1:0]  rdelm_valuetoadd,
    output logic [ELMWIDTH-1:0]  wrelm_valuetoadd,
    output logic [CNTWIDTH-1:0]  count_valuetoadd,
    output logic                 retire,
    output logic                 busy
);

    typedef enum logic [2:0] {
        MODE_RESET,
        MODE_STALL,
        MODE_IDLE,
        MODE_SHIFT,
        MODE_STEP
    } mode_e;

    mode_e                mode;
    logic [NUMSTAGES-1:0] valid;
    logic [CNTWIDTH-1:0]  rem [NUMSTAGES];
    logic [ELMWIDTH:0]    vl_sum;
    logic [CNTWIDTH-1:0]  groups;
    logic                 exit_done;
    logic                 any_valid;
    logic                 in_ready;

    // One extra bit so vl near 2^ELMWIDTH-1 does not wrap before the shift.
    assign vl_sum = {1'b0, dec.in_vl} + (ELMWIDTH+1)'(LANES - 1);
    assign groups = CNTWIDTH'(vl_sum >> LOG2LANES);

    assign any_valid = |valid;
    assign exit_done = ~valid[NUMSTAGES-1] | (rem[NUMSTAGES-1] == '0);

    // Dispatcher datapath constants: elements advance by a group, count drops by one.
    assign rotate           = 1'b0;
    assign inshift_rdelm    = '0;
    assign inshift_wrelm    = '0;
    assign rdelm_add_sub    = 1'b0;
    assign wrelm_add_sub    = 1'b0;
    assign count_add_sub    = 1'b1;
    assign rdelm_valuetoadd = ELMWIDTH'(LANES);
    assign wrelm_valuetoadd = ELMWIDTH'(LANES);
    assign count_valuetoadd = CNTWIDTH'(1);
    assign dec.in_ready     = in_ready;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        mode          = MODE_IDLE;
        shift         = 1'b0;
        in_ready      = 1'b0;
        increment     = '0;
        retire        = 1'b0;
        busy          = 1'b0;
        inshift_instr = '0;
        inshift_first = 1'b0;
        inshift_count = '0;

        if (reset)
            mode = MODE_RESET;
        else if (stall)
            mode = MODE_STALL;
        else if (!exit_done)
            mode = MODE_STEP;
        else if (any_valid || dec.in_valid)
            mode = MODE_SHIFT;
        else
            mode = MODE_IDLE;

        if (mode != MODE_RESET)
            busy = any_valid;

        case (mode)
            MODE_IDLE: begin
                in_ready = 1'b1;
            end
            MODE_SHIFT: begin
                shift    = 1'b1;
                in_ready = 1'b1;
                retire   = valid[NUMSTAGES-1];
                // A bubble enters slot 0 as all zeros when nothing is offered.
                if (dec.in_valid) begin
                    inshift_instr = dec.in_instr;
                    inshift_first = 1'b1;
                    inshift_count = groups;
                end
            end
            MODE_STEP: begin
                for (int i = 0; i < NUMSTAGES; i++)
                    increment[i] = valid[i] && (rem[i] != '0);
            end
            default: ;
        endcase
    end

    // NOTE: reset is synchronous, so it is just the first branch of the clocked block;
    // shadow state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            for (int i = 0; i < NUMSTAGES; i++)
                rem[i] <= '0;
        end else begin
            case (mode)
                MODE_SHIFT: begin
                    for (int i = 1; i < NUMSTAGES; i++) begin
                        valid[i] <= valid[i-1];
                        rem[i]   <= rem[i-1];
                    end
                    valid[0] <= dec.in_valid;
                    rem[0]   <= dec.in_valid ? groups : '0;
                end
                MODE_STEP: begin
                    // increment is only set where rem is non-zero, so no underflow.
                    for (int i = 0; i < NUMSTAGES; i++)
                        if (increment[i])
                            rem[i] <= rem[i] - CNTWIDTH'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vdispatch_issuer.sv
// Table-driven bench for vdispatch_issuer: one cycle per vector, outputs checked
// at the falling edge, plus a hand-written long-vector run with a bounded wait.
module tb_vdispatch_issuer;

    localparam int NUMSTAGES = 2;
    localparam int WIDTH     = 157;
    localparam int ELMWIDTH  = 7;
    localparam int CNTWIDTH  = 3;
    localparam int LANES     = 32;
    localparam int LOG2LANES = 5;

    logic clk = 1'b0;
    logic reset;
    logic stall;
    logic                 shift, rotate, inshift_first, retire, busy;
    logic [WIDTH-1:0]     inshift_instr;
    logic [ELMWIDTH-1:0]  inshift_rdelm, inshift_wrelm, rdelm_valuetoadd, wrelm_valuetoadd;
    logic [CNTWIDTH-1:0]  inshift_count, count_valuetoadd;
    logic [NUMSTAGES-1:0] increment;
    logic                 rdelm_add_sub, wrelm_add_sub, count_add_sub;

    vdispatch_issuer_if #(.WIDTH(WIDTH), .ELMWIDTH(ELMWIDTH)) dec_if ();

    vdispatch_issuer #(
        .NUMSTAGES(NUMSTAGES), .WIDTH(WIDTH), .ELMWIDTH(ELMWIDTH),
        .CNTWIDTH(CNTWIDTH), .LANES(LANES), .LOG2LANES(LOG2LANES)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .dec              (dec_if.slave),
        .stall            (stall),
        .shift            (shift),
        .rotate           (rotate),
        .inshift_instr    (inshift_instr),
        .inshift_first    (inshift_first),
        .inshift_rdelm    (inshift_rdelm),
        .inshift_wrelm    (inshift_wrelm),
        .inshift_count    (inshift_count),
        .increment        (increment),
        .rdelm_add_sub    (rdelm_add_sub),
        .wrelm_add_sub    (wrelm_add_sub),
        .count_add_sub    (count_add_sub),
        .rdelm_valuetoadd (rdelm_valuetoadd),
        .wrelm_valuetoadd (wrelm_valuetoadd),
        .count_valuetoadd (count_valuetoadd),
        .retire           (retire),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [6:0] vl;
        logic       stl;
        logic       e_rdy;
        logic       e_shift;
        logic [1:0] e_inc;
        logic       e_ret;
        logic       e_busy;
        logic       e_first;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic rst, input logic vld, input int vl, input logic stl,
                                input logic rdy, input logic sh, input logic [1:0] inc,
                                input logic ret, input logic bsy, input logic fst, input int cnt);
        vec_t v;
        v.rst = rst; v.vld = vld; v.vl = 7'(vl); v.stl = stl;
        v.e_rdy = rdy; v.e_shift = sh; v.e_inc = inc; v.e_ret = ret;
        v.e_busy = bsy; v.e_first = fst; v.e_cnt = 3'(cnt);
        return v;
    endfunction

    task automatic drive(input logic rst, input logic vld, input logic [6:0] vl,
                         input logic stl, input int tag);
        logic [159:0] pat;
        pat = {5{32'h5A5A_0000 ^ 32'(tag)}};
        reset           = rst;
        stall           = stl;
        dec_if.in_valid = vld;
        dec_if.in_vl    = vl;
        dec_if.in_instr = WIDTH'(pat);
    endtask

    initial begin
        logic [WIDTH-1:0] exp_instr;
        int incs;
        int rets;
        bit done;

        drive(1'b1, 1'b0, 7'd0, 1'b0, 0);

        // rst vld vl stl | rdy shift inc ret busy first cnt
        // reset held with a pending instruction
        vecs.push_back(mk(1, 1, 70, 0,  0, 0, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 70, 0,  0, 0, 2'b00, 0, 0, 0, 0));
        // single vl=70 instruction: 3 groups
        vecs.push_back(mk(0, 1, 70, 0,  1, 1, 2'b00, 0, 0, 1, 3));
        vecs.push_back(mk(0, 0, 0,  0,  1, 1, 2'b00, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0,  0, 0, 2'b10, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0,  0, 0, 2'b10, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0,  0, 0, 2'b10, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0,  1, 1, 2'b00, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0,  1, 0, 2'b00, 0, 0, 0, 0));
        // back-to-back A,B with vl=32: 1 group each
        vecs.push_back(mk(0, 1, 32, 0,  1, 1, 2'b00, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 32, 0,  1, 1, 2'b00, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0,  0,  0, 0, 2'b11, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0,  1, 1, 2'b00, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0,  1, 1, 2'b00, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0,  1, 0, 2'b00, 0, 0, 0, 0));
        // vl=0: zero groups, never stepped
        vecs.push_back(mk(0, 1, 0,  0,  1, 1, 2'b00, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0,  0,  1, 1, 2'b00, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0,  1, 1, 2'b00, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0,  1, 0, 2'b00, 0, 0, 0, 0));
        // vl=96 (3 groups) with a 3-cycle stall after the first step
        vecs.push_back(mk(0, 1, 96, 0,  1, 1, 2'b00, 0, 0, 1, 3));
        vecs.push_back(mk(0, 0, 0,  0,  1, 1, 2'b00, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0,  0, 0, 2'b10, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 32, 1,  0, 0, 2'b00, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 32, 1,  0, 0, 2'b00, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  1,  0, 0, 2'b00, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0,  0, 0, 2'b10, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0,  0, 0, 2'b10, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0,  1, 1, 2'b00, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0,  1, 0, 2'b00, 0, 0, 0, 0));
        // reset in the middle of a vl=70 run: no retire afterwards
        vecs.push_back(mk(0, 1, 70, 0,  1, 1, 2'b00, 0, 0, 1, 3));
        vecs.push_back(mk(0, 0, 0,  0,  1, 1, 2'b00, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0,  0, 0, 2'b10, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0,  0,  0, 0, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0,  1, 0, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0,  1, 0, 2'b00, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0,  1, 0, 2'b00, 0, 0, 0, 0));
        // group rounding: vl=1 -> 1, vl=33 -> 2 (insertion only, then reset)
        vecs.push_back(mk(0, 1, 1,  0,  1, 1, 2'b00, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 33, 0,  1, 1, 2'b00, 0, 1, 1, 2));
        vecs.push_back(mk(1, 0, 0,  0,  0, 0, 2'b00, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].rst, vecs[i].vld, vecs[i].vl, vecs[i].stl, i);
            @(negedge clk);
            exp_instr = vecs[i].e_first ? dec_if.in_instr : '0;
            check($sformatf("v%0d in_ready", i),  160'(dec_if.in_ready), 160'(vecs[i].e_rdy));
            check($sformatf("v%0d shift", i),     160'(shift),           160'(vecs[i].e_shift));
            check($sformatf("v%0d increment", i), 160'(increment),       160'(vecs[i].e_inc));
            check($sformatf("v%0d retire", i),    160'(retire),          160'(vecs[i].e_ret));
            check($sformatf("v%0d busy", i),      160'(busy),            160'(vecs[i].e_busy));
            check($sformatf("v%0d first", i),     160'(inshift_first),   160'(vecs[i].e_first));
            check($sformatf("v%0d count", i),     160'(inshift_count),   160'(vecs[i].e_cnt));
            check($sformatf("v%0d instr", i),     160'(inshift_instr),   160'(exp_instr));
        end

        // Fixed dispatcher controls
        check("rotate",           160'(rotate),           160'(0));
        check("inshift_rdelm",    160'(inshift_rdelm),    160'(0));
        check("inshift_wrelm",    160'(inshift_wrelm),    160'(0));
        check("rdelm_add_sub",    160'(rdelm_add_sub),    160'(0));
        check("wrelm_add_sub",    160'(wrelm_add_sub),    160'(0));
        check("count_add_sub",    160'(count_add_sub),    160'(1));
        check("rdelm_valuetoadd", 160'(rdelm_valuetoadd), 160'(32));
        check("wrelm_valuetoadd", 160'(wrelm_valuetoadd), 160'(32));
        check("count_valuetoadd", 160'(count_valuetoadd), 160'(1));

        // Longest vector, vl=127 -> 4 groups: exactly 4 exit-slot steps then one retire
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 7'd127, 1'b0, 99);
        @(negedge clk);
        check("vl127 shift", 160'(shift),         160'(1));
        check("vl127 count", 160'(inshift_count), 160'(4));
        incs = 0;
        rets = 0;
        done = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            @(posedge clk);
            #1;
            drive(1'b0, 1'b0, 7'd0, 1'b0, 0);
            @(negedge clk);
            if (increment[1]) incs++;
            if (shift && increment != '0) check("inc in shift", 160'(increment), 160'(0));
            if (retire) begin
                rets++;
                done = 1'b1;
            end
        end
        check("vl127 retired",    160'(rets), 160'(1));
        check("vl127 increments", 160'(incs), 160'(4));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("vl127 idle busy",  160'(busy),            160'(0));
        check("vl127 idle ready", 160'(dec_if.in_ready), 160'(1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
